pixel_frame_writer: RTL and testbench
=====================================

# pixel_frame_writer

Receiving end of the per-pixel shading pipeline: consumes the stream of (x, y, 4-bit r/g/b, valid) results produced by the pixel-colour formatter and writes them as packed 12-bit RGB words into the framebuffer BRAM write port. The upstream pipeline cannot stall, so the block buffers in a small FIFO, drops and flags what it cannot store, and counts completed frames. It also provides a background-clear sweep of the whole framebuffer on request.

## Interface
- H_RES, 320, framebuffer width in pixels
- V_RES, 180, framebuffer height in pixels
- ADDR_W, 16, framebuffer address width; must satisfy 2^ADDR_W ≥ H_RES·V_RES
- FIFO_DEPTH, 8, entries in the decoupling FIFO; power of two
- BG_COLOR, 12'h000, word written during clear

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous, active-high reset
- x_in  in  11  pixel column
- y_in  in  11  pixel row
- r_in, g_in, b_in  in  4 each  colour channels
- rgb_valid_in  in  1  pixel qualifier, at most one pixel per cycle, no backpressure
- clear_start_in  in  1  one-cycle request to clear the framebuffer
- fb_addr_out  out  ADDR_W  BRAM write address
- fb_data_out  out  12  BRAM write data {r,g,b}
- fb_we_out  out  1  BRAM write enable
- busy_out  out  1  high while clearing
- frame_done_out  out  1  one-cycle pulse per completed frame
- pixel_count_out  out  ADDR_W  pixel writes in current frame
- overflow_out  out  1  sticky: a pixel was dropped because the FIFO was full
- oob_out  out  1  sticky: a pixel with x ≥ H_RES or y ≥ V_RES was received

## Operation
- Stage A, registered: on rgb_valid_in, range check. In range: addr = y_in·H_RES + x_in (ADDR_W bits, no wrap), data = {r_in,g_in,b_in}. Out of range: discarded, oob_out set.
- Stage B: Stage A result pushed into FIFO. If FIFO full: pixel dropped, overflow_out set, pixel_count unchanged.
- FSM states IDLE, CLEAR.
  - IDLE: each cycle with FIFO non-empty, pop one entry and write it (fb_we_out=1). pixel_count increments per FIFO write. At count H_RES·V_RES−1 the write also pulses frame_done_out and count returns to 0.
  - IDLE→CLEAR on clear_start_in: clear counter reset to 0, pixel_count reset to 0.
  - CLEAR: write BG_COLOR to address clear counter, incrementing each cycle. FIFO is not popped but still accepts pushes. After address H_RES·V_RES−1: return to IDLE.
- clear_start_in while in CLEAR is ignored; it does not restart the sweep.
- Sticky flags clear only on rst_in.

## Timing
- Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0. No automatic clear.
- Latency: pixel valid at edge N with FIFO empty and state IDLE → fb_we_out high in the cycle after edge N+2, i.e. exactly 2 cycles.
- Throughput: 1 write/cycle; a sustained 1 pixel/cycle input never overflows in IDLE.
- Clear: busy_out rises the cycle after clear_start_in. Exactly H_RES·V_RES consecutive write cycles follow. busy_out falls on the cycle after the final clear write. The first FIFO pop may occur in that same cycle.
- Simultaneous clear_start_in and rgb_valid_in: the pixel is buffered and written after the clear completes.
- FIFO full and pop in the same cycle: the push succeeds.
- rst_in mid-clear or mid-stream: fb_we_out is 0 in the next cycle and all state returns to reset values. The partial framebuffer contents are left as they are.

## Structure
- Package fb_pkg holds:
  - default H_RES/V_RES constants
  - fb_state_t enum {IDLE, CLEAR}
  - packed struct fb_pixel_t {addr, rgb12}
- Sub-module pixel_fifo: a synchronous FIFO of fb_pixel_t with push, pop, full and empty, and a registered read-data output. It is parameterised by depth.
- The address multiply is a constant-coefficient multiply in Stage A.

## Test plan
- Pixel x=3, y=2, rgb F/8/1, H_RES=320 → 2 cycles later fb_we_out=1, fb_addr_out=643, fb_data_out=12'hF81, pixel_count_out=1.
- Pixel x=320, y=0 → no write, oob_out=1 persists. Then x=319, y=179 → addr 57599 written.
- clear_start_in pulse (320×180) → busy_out high for 57600 cycles with writes to addr 0..57599 of 12'h000, then busy_out=0. A second pulse mid-sweep has no effect.
- 10 consecutive pixels during CLEAR with FIFO_DEPTH=8 → overflow_out=1. After the clear, exactly the first 8 pixels are written in arrival order.
- H_RES=4, V_RES=2: 8 in-range pixels → frame_done_out high for one cycle, coincident with the 8th write, and pixel_count_out=0 afterwards. A 9th pixel gives count 1.
- rst_in asserted at clear address 100 with 3 pixels queued → next cycle fb_we_out=0, busy_out=0, no queued pixel is ever written, and all flags and counters are 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and defaults for the pixel framebuffer writer:
// frame geometry, FSM state encoding and the buffered pixel record.
package fb_pkg;

    localparam int FB_H_RES  = 320;
    localparam int FB_V_RES  = 180;
    localparam int FB_ADDR_W = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [11:0]          rgb12;
    } fb_pixel_t;

    function automatic logic [11:0] pack_rgb(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/pixel_frame_writer_if.sv
// Pixel stream in / framebuffer write port out, plus status, as one bundle.
// The master side is the pixel source and BRAM/status observer; the slave is the writer.
interface pixel_frame_writer_if
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W
) ();
    logic [10:0]       x_in;
    logic [10:0]       y_in;
    logic [3:0]        r_in;
    logic [3:0]        g_in;
    logic [3:0]        b_in;
    logic              rgb_valid_in;
    logic              clear_start_in;
    logic [ADDR_W-1:0] fb_addr_out;
    logic [11:0]       fb_data_out;
    logic              fb_we_out;
    logic              busy_out;
    logic              frame_done_out;
    logic [ADDR_W-1:0] pixel_count_out;
    logic              overflow_out;
    logic              oob_out;

    modport master (
        output x_in, y_in, r_in, g_in, b_in, rgb_valid_in, clear_start_in,
        input  fb_addr_out, fb_data_out, fb_we_out, busy_out, frame_done_out,
               pixel_count_out, overflow_out, oob_out
    );

    modport slave (
        input  x_in, y_in, r_in, g_in, b_in, rgb_valid_in, clear_start_in,
        output fb_addr_out, fb_data_out, fb_we_out, busy_out, frame_done_out,
               pixel_count_out, overflow_out, oob_out
    );
endinterface

// File: rtl/pixel_frame_writer_fifo.sv
// Synchronous FIFO of fb_pixel_t with a registered read-data output.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module pixel_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      push,
    input  fb_pixel_t wr_data,
    input  logic      pop,
    output fb_pixel_t rd_data,
    output logic      full,
    output logic      empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    fb_pixel_t        mem_r [DEPTH];
    fb_pixel_t        rd_data_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against occupancy.
    always_comb begin
        do_pop_s  = pop && (cnt_r != CNT_W'(0));
        do_push_s = push && ((cnt_r != CNT_W'(DEPTH)) || do_pop_s);
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk_in) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and the read-data register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_r  <= PTR_W'(0);
            rd_ptr_r  <= PTR_W'(0);
            cnt_r     <= CNT_W'(0);
            rd_data_r <= '{addr: FB_ADDR_W'(0), rgb12: 12'h000};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_data_r <= mem_r[rd_ptr_r];
                rd_ptr_r  <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign rd_data = rd_data_r;
    assign full    = (cnt_r == CNT_W'(DEPTH));
    assign empty   = (cnt_r == CNT_W'(0));

endmodule

// File: rtl/pixel_frame_writer.sv
// Writes the non-stallable pixel stream into the framebuffer through a small FIFO,
// counts frames, flags drops/out-of-range pixels and sweeps a background clear on request.
module pixel_frame_writer
    import fb_pkg::*;
#(
    parameter int          H_RES      = FB_H_RES,
    parameter int          V_RES      = FB_V_RES,
    parameter int          ADDR_W     = FB_ADDR_W,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    pixel_frame_writer_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [10:0]       H_LIM     = 11'(H_RES);
    localparam logic [10:0]       V_LIM     = 11'(V_RES);

    fb_state_t         state_r, next_state_s;
    logic              a_valid_r;
    fb_pixel_t         a_pix_r;
    logic              in_range_s;
    logic [ADDR_W-1:0] addr_s;
    fb_pixel_t         fifo_rd_s;
    logic              full_s, empty_s;
    logic              pop_s, clr_go_s;
    logic [ADDR_W-1:0] clr_cnt_r, pix_cnt_r;
    logic              fb_we_r, clr_act_r, frame_done_r, overflow_r, oob_r;

    // Range check and constant-coefficient address multiply.
    always_comb begin
        in_range_s = (bus.x_in < H_LIM) && (bus.y_in < V_LIM);
        addr_s     = ADDR_W'(bus.y_in) * ADDR_W'(H_RES) + ADDR_W'(bus.x_in);
    end

    // Stage A register: accepted pixel record and sticky out-of-range flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_valid_r <= 1'b0;
            a_pix_r   <= '{addr: FB_ADDR_W'(0), rgb12: 12'h000};
            oob_r     <= 1'b0;
        end else begin
            a_valid_r <= bus.rgb_valid_in && in_range_s;
            if (bus.rgb_valid_in && in_range_s) begin
                a_pix_r <= '{addr: FB_ADDR_W'(addr_s), rgb12: pack_rgb(bus.r_in, bus.g_in, bus.b_in)};
            end
            if (bus.rgb_valid_in && !in_range_s) begin
                oob_r <= 1'b1;
            end
        end
    end

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push    (a_valid_r),
        .wr_data (a_pix_r),
        .pop     (pop_s),
        .rd_data (fifo_rd_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state; a clear request during a sweep does not restart it.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = bus.clear_start_in ? CLEAR : IDLE;
            CLEAR:   next_state_s = (clr_cnt_r == LAST_ADDR) ? IDLE : CLEAR;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM outputs; the FIFO is drained only while idle and not starting a clear.
    always_comb begin
        pop_s    = 1'b0;
        clr_go_s = 1'b0;
        case (state_r)
            IDLE: begin
                clr_go_s = bus.clear_start_in;
                pop_s    = !bus.clear_start_in && !empty_s;
            end
            CLEAR: begin
                clr_go_s = 1'b0;
                pop_s    = 1'b0;
            end
            default: begin
                clr_go_s = 1'b0;
                pop_s    = 1'b0;
            end
        endcase
    end

    // Write strobe, clear sweep address, frame counter and drop flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fb_we_r      <= 1'b0;
            clr_act_r    <= 1'b0;
            frame_done_r <= 1'b0;
            clr_cnt_r    <= ADDR_W'(0);
            pix_cnt_r    <= ADDR_W'(0);
            overflow_r   <= 1'b0;
        end else begin
            fb_we_r      <= pop_s || (next_state_s == CLEAR);
            clr_act_r    <= (next_state_s == CLEAR);
            frame_done_r <= pop_s && (pix_cnt_r == LAST_ADDR);
            if (clr_go_s) begin
                clr_cnt_r <= ADDR_W'(0);
            end else if ((state_r == CLEAR) && (clr_cnt_r != LAST_ADDR)) begin
                clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
            end
            if (clr_go_s) begin
                pix_cnt_r <= ADDR_W'(0);
            end else if (pop_s) begin
                pix_cnt_r <= (pix_cnt_r == LAST_ADDR) ? ADDR_W'(0) : pix_cnt_r + ADDR_W'(1);
            end
            if (a_valid_r && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Output selection is driven only by registers, so the outputs never see input paths.
    assign bus.fb_we_out       = fb_we_r;
    assign bus.fb_addr_out     = clr_act_r ? clr_cnt_r : ADDR_W'(fifo_rd_s.addr);
    assign bus.fb_data_out     = clr_act_r ? BG_COLOR : fifo_rd_s.rgb12;
    assign bus.busy_out        = clr_act_r;
    assign bus.frame_done_out  = frame_done_r;
    assign bus.pixel_count_out = pix_cnt_r;
    assign bus.overflow_out    = overflow_r;
    assign bus.oob_out         = oob_r;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed bench for pixel_frame_writer: a full-size 320x180 instance and a tiny 4x2
// instance for frame wrap; expected values are hand-derived from the pixel pattern.
module tb_pixel_frame_writer;

    logic clk_in = 1'b0;
    logic rst_big, rst_small;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_in = ~clk_in;

    pixel_frame_writer_if #(.ADDR_W(16)) big_if ();
    pixel_frame_writer_if #(.ADDR_W(16)) small_if ();

    pixel_frame_writer #(.H_RES(320), .V_RES(180), .ADDR_W(16), .FIFO_DEPTH(8), .BG_COLOR(12'h000))
        u_big (.clk_in(clk_in), .rst_in(rst_big), .bus(big_if.slave));

    pixel_frame_writer #(.H_RES(4), .V_RES(2), .ADDR_W(16), .FIFO_DEPTH(8), .BG_COLOR(12'h000))
        u_small (.clk_in(clk_in), .rst_in(rst_small), .bus(small_if.slave));

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Colour pattern for pixel number i: {i, 15-i, 3}.
    function automatic logic [11:0] px_rgb(input int i);
        logic [3:0] a;
        a = 4'(i);
        return {a, 4'hF - a, 4'h3};
    endfunction

    task automatic drive_big(input int x, input int y, input logic [11:0] rgb);
        big_if.x_in = 11'(x);
        big_if.y_in = 11'(y);
        big_if.r_in = rgb[11:8];
        big_if.g_in = rgb[7:4];
        big_if.b_in = rgb[3:0];
        big_if.rgb_valid_in = 1'b1;
    endtask

    task automatic drive_small(input int x, input int y, input logic [11:0] rgb);
        small_if.x_in = 11'(x);
        small_if.y_in = 11'(y);
        small_if.r_in = rgb[11:8];
        small_if.g_in = rgb[7:4];
        small_if.b_in = rgb[3:0];
        small_if.rgb_valid_in = 1'b1;
    endtask

    initial begin
        int          busy_cycles, bad, cyc, nw, sw, fd_cnt, fd_at;
        logic        done, hit, seen;
        logic [15:0] exp_a;
        logic [15:0] wa [16];
        logic [11:0] wd [16];

        big_if.x_in = 11'd0; big_if.y_in = 11'd0;
        big_if.r_in = 4'd0; big_if.g_in = 4'd0; big_if.b_in = 4'd0;
        big_if.rgb_valid_in = 1'b0; big_if.clear_start_in = 1'b0;
        small_if.x_in = 11'd0; small_if.y_in = 11'd0;
        small_if.r_in = 4'd0; small_if.g_in = 4'd0; small_if.b_in = 4'd0;
        small_if.rgb_valid_in = 1'b0; small_if.clear_start_in = 1'b0;
        rst_big = 1'b1; rst_small = 1'b1;
        repeat (3) @(negedge clk_in);

        check_val("rst_we",    32'(big_if.fb_we_out), 32'd0);
        check_val("rst_busy",  32'(big_if.busy_out), 32'd0);
        check_val("rst_cnt",   32'(big_if.pixel_count_out), 32'd0);
        check_val("rst_flags", 32'({big_if.overflow_out, big_if.oob_out, big_if.frame_done_out}), 32'd0);
        check_val("rst_addr",  32'(big_if.fb_addr_out), 32'd0);
        rst_big = 1'b0; rst_small = 1'b0;
        @(negedge clk_in);

        // Tiny frame: 8 back-to-back pixels wrap the frame exactly once.
        sw = 0; fd_cnt = 0; fd_at = -1; bad = 0;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) drive_small(c % 4, c / 4, px_rgb(c));
            else small_if.rgb_valid_in = 1'b0;
            @(negedge clk_in);
            if (small_if.fb_we_out) begin
                if (small_if.fb_addr_out != 16'(sw)) bad++;
                if (small_if.fb_data_out != px_rgb(sw)) bad++;
                if (small_if.pixel_count_out != 16'((sw + 1) % 8)) bad++;
                if (small_if.frame_done_out) fd_at = sw;
                sw++;
            end
            if (small_if.frame_done_out) fd_cnt++;
        end
        check_val("small_writes",   32'(sw), 32'd8);
        check_val("small_seq",      32'(bad), 32'd0);
        check_val("small_fd_count", 32'(fd_cnt), 32'd1);
        check_val("small_fd_at",    32'(fd_at), 32'd7);
        check_val("small_cnt_wrap", 32'(small_if.pixel_count_out), 32'd0);
        check_val("small_no_ovf",   32'(small_if.overflow_out), 32'd0);
        drive_small(1, 0, 12'h123);
        @(negedge clk_in); small_if.rgb_valid_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        check_val("small_9th_we",   32'(small_if.fb_we_out), 32'd1);
        check_val("small_9th_addr", 32'(small_if.fb_addr_out), 32'd1);
        check_val("small_9th_cnt",  32'(small_if.pixel_count_out), 32'd1);

        // Basic write and its two-cycle latency.
        drive_big(3, 2, 12'hF81);
        @(negedge clk_in); big_if.rgb_valid_in = 1'b0;
        @(negedge clk_in);
        check_val("lat_early_we", 32'(big_if.fb_we_out), 32'd0);
        @(negedge clk_in);
        check_val("px_we",   32'(big_if.fb_we_out), 32'd1);
        check_val("px_addr", 32'(big_if.fb_addr_out), 32'd643);
        check_val("px_data", 32'(big_if.fb_data_out), 32'hF81);
        check_val("px_cnt",  32'(big_if.pixel_count_out), 32'd1);

        // Out-of-range pixel then the last in-range corner.
        drive_big(320, 0, 12'hABC);
        @(negedge clk_in); big_if.rgb_valid_in = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            seen = seen | big_if.fb_we_out;
        end
        check_val("oob_no_write", 32'(seen), 32'd0);
        check_val("oob_flag",     32'(big_if.oob_out), 32'd1);
        drive_big(319, 179, 12'h5A5);
        @(negedge clk_in); big_if.rgb_valid_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        check_val("corner_we",   32'(big_if.fb_we_out), 32'd1);
        check_val("corner_addr", 32'(big_if.fb_addr_out), 32'd57599);
        check_val("corner_data", 32'(big_if.fb_data_out), 32'h5A5);
        check_val("corner_cnt",  32'(big_if.pixel_count_out), 32'd2);
        check_val("oob_sticky",  32'(big_if.oob_out), 32'd1);
        @(negedge clk_in);

        // Full clear with a coincident pixel, 9 more pixels and an ignored second request.
        big_if.clear_start_in = 1'b1;
        drive_big(0, 5, px_rgb(0));
        busy_cycles = 0; bad = 0; cyc = 0; done = 1'b0; exp_a = 16'd0;
        while (!done && cyc < 60000) begin
            @(negedge clk_in);
            big_if.clear_start_in = (cyc == 1000);
            if (cyc < 9) drive_big(cyc + 1, 5, px_rgb(cyc + 1));
            else big_if.rgb_valid_in = 1'b0;
            if (cyc == 0) begin
                check_val("clr_busy_rise",  32'(big_if.busy_out), 32'd1);
                check_val("clr_first_addr", 32'(big_if.fb_addr_out), 32'd0);
            end
            if (big_if.busy_out) begin
                busy_cycles++;
                if (!big_if.fb_we_out || big_if.fb_addr_out != exp_a || big_if.fb_data_out != 12'h000) bad++;
                exp_a = exp_a + 16'd1;
            end else begin
                done = 1'b1;
            end
            cyc++;
        end
        big_if.clear_start_in = 1'b0;
        check_val("clr_terminated", 32'(done), 32'd1);
        check_val("clr_busy_len",   32'(busy_cycles), 32'd57600);
        check_val("clr_sweep_seq",  32'(bad), 32'd0);
        check_val("clr_overflow",   32'(big_if.overflow_out), 32'd1);
        nw = 0;
        for (int k = 0; k < 20; k++) begin
            if (big_if.fb_we_out) begin
                if (nw < 16) begin
                    wa[nw] = big_if.fb_addr_out;
                    wd[nw] = big_if.fb_data_out;
                end
                nw++;
            end
            @(negedge clk_in);
        end
        check_val("drain_count", 32'(nw), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("drain_addr%0d", i), 32'(wa[i]), 32'(1600 + i));
            check_val($sformatf("drain_data%0d", i), 32'(wd[i]), 32'(px_rgb(i)));
        end
        check_val("drain_pix_cnt", 32'(big_if.pixel_count_out), 32'd8);

        // Reset in the middle of a clear with pixels queued.
        big_if.clear_start_in = 1'b1;
        hit = 1'b0; cyc = 0;
        while (!hit && cyc < 300) begin
            @(negedge clk_in);
            big_if.clear_start_in = 1'b0;
            if (cyc >= 10 && cyc < 13) drive_big(cyc, 7, px_rgb(cyc));
            else big_if.rgb_valid_in = 1'b0;
            if (big_if.busy_out && big_if.fb_addr_out == 16'd100) hit = 1'b1;
            cyc++;
        end
        check_val("rst_mid_reached", 32'(hit), 32'd1);
        rst_big = 1'b1;
        big_if.rgb_valid_in = 1'b0;
        @(negedge clk_in);
        rst_big = 1'b0;
        check_val("rst_mid_we",    32'(big_if.fb_we_out), 32'd0);
        check_val("rst_mid_busy",  32'(big_if.busy_out), 32'd0);
        check_val("rst_mid_cnt",   32'(big_if.pixel_count_out), 32'd0);
        check_val("rst_mid_flags", 32'({big_if.overflow_out, big_if.oob_out, big_if.frame_done_out}), 32'd0);
        nw = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (big_if.fb_we_out || big_if.busy_out) nw++;
        end
        check_val("rst_mid_no_writes", 32'(nw), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
